// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter. Port A has priority, port B is protected
// from starvation by a force-grant counter and may take exclusive ownership
// of the memory (LOCK) for a bounded number of cycles.
module data_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8,
  parameter int MEM_WORDS    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqA,
  input  logic        reqB,
  input  logic [31:0] addrA,
  input  logic [31:0] addrB,
  input  logic [31:0] wdataA,
  input  logic [31:0] wdataB,
  input  logic        weA,
  input  logic        weB,
  input  logic        lockB,
  output logic        gntA,
  output logic        gntB,
  output logic        stallA,
  output logic [31:0] rdataA,
  output logic [31:0] rdataB,
  output logic        rvalidA,
  output logic        rvalidB,
  output logic        errA,
  output logic        errB,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_writeData,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_readData
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 1);
  localparam logic [31:0]   MEM_LIMIT  = 32'(MEM_WORDS);

  typedef enum logic {ARB, LOCK} state_t;

  state_t        state_reg;
  logic [SW-1:0] starve_cnt_reg;
  logic [LW-1:0] lock_cnt_reg;
  logic          lock_inhibit_reg;
  logic [31:0]   last_adr_reg;

  logic          force_b;
  logic          gnt_a;
  logic          gnt_b;
  logic          any_gnt;
  logic          sel_we;
  logic          sel_in_range;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;

  // B has waited long enough: it wins the next arbitration regardless of A
  assign force_b = (starve_cnt_reg == STARVE_MAX);

  // Grant decision: A first unless B is forced; only B in LOCK; nothing in reset
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst) begin
      if (state_reg == LOCK) begin
        gnt_b = reqB;
      end else begin
        gnt_a = reqA & ~force_b;
        gnt_b = reqB & ~gnt_a;
      end
    end
  end

  assign gntA   = gnt_a;
  assign gntB   = gnt_b;
  assign stallA = rst & reqA & ~gnt_a;

  assign any_gnt      = gnt_a | gnt_b;
  assign sel_addr     = gnt_a ? addrA  : addrB;
  assign sel_wdata    = gnt_a ? wdataA : wdataB;
  assign sel_we       = gnt_a ? weA    : weB;
  assign sel_in_range = (sel_addr < MEM_LIMIT);

  // Out-of-range or idle slots leave the address parked on the last real access
  assign mem_adr       = (any_gnt & sel_in_range) ? sel_addr : last_adr_reg;
  assign mem_writeData = sel_wdata;
  assign mem_memread   = any_gnt & sel_in_range & ~sel_we;
  assign mem_memwrite  = any_gnt & sel_in_range & sel_we;

  // Arbitration state: ARB/LOCK, starvation counter, lock timer and inhibit
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg        <= ARB;
      starve_cnt_reg   <= '0;
      lock_cnt_reg     <= '0;
      lock_inhibit_reg <= 1'b0;
      last_adr_reg     <= '0;
    end else begin
      if (reqB & ~gnt_b) begin
        if (starve_cnt_reg != STARVE_MAX)
          starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end else begin
        starve_cnt_reg <= '0;
      end

      if (any_gnt & sel_in_range)
        last_adr_reg <= sel_addr;

      // Inhibit survives until B lets go of lockB, so a timed-out lock
      // cannot be immediately re-acquired by a B that never released it
      if (!lockB)
        lock_inhibit_reg <= 1'b0;
      else if (state_reg == LOCK && lock_cnt_reg == LOCK_LAST)
        lock_inhibit_reg <= 1'b1;

      case (state_reg)
        ARB: begin
          if (gnt_b & lockB & ~lock_inhibit_reg) begin
            state_reg    <= LOCK;
            lock_cnt_reg <= '0;
          end
        end
        LOCK: begin
          lock_cnt_reg <= lock_cnt_reg + 1'b1;
          if (!lockB || lock_cnt_reg == LOCK_LAST)
            state_reg <= ARB;
        end
        default: state_reg <= ARB;
      endcase
    end
  end

  logic [1:0]  port_gnt;
  logic [1:0]  port_we;
  logic [31:0] rdata_reg [2];
  logic [1:0]  rvalid_reg;
  logic [1:0]  err_reg;

  assign port_gnt = {gnt_b, gnt_a};
  assign port_we  = {weB, weA};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      // Per-port return path: capture read data, pulse rvalid/err for one cycle
      always_ff @(posedge clk) begin
        if (!rst) begin
          rdata_reg[gi]  <= '0;
          rvalid_reg[gi] <= 1'b0;
          err_reg[gi]    <= 1'b0;
        end else begin
          rvalid_reg[gi] <= 1'b0;
          err_reg[gi]    <= 1'b0;
          if (port_gnt[gi]) begin
            if (sel_in_range) begin
              if (!port_we[gi]) begin
                rdata_reg[gi]  <= mem_readData;
                rvalid_reg[gi] <= 1'b1;
              end
            end else begin
              err_reg[gi] <= 1'b1;
              if (!port_we[gi]) begin
                rdata_reg[gi]  <= '0;
                rvalid_reg[gi] <= 1'b1;
              end
            end
          end
        end
      end
    end
  endgenerate

  assign rdataA  = rdata_reg[0];
  assign rdataB  = rdata_reg[1];
  assign rvalidA = rvalid_reg[0];
  assign rvalidB = rvalid_reg[1];
  assign errA    = err_reg[0];
  assign errB    = err_reg[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural word memory on the
// mem_* side. Inputs change 1 time unit after the rising edge; combinational
// outputs are checked 1 unit later, registered outputs after the next edge.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqA, reqB, weA, weB, lockB;
  logic [31:0] addrA, addrB, wdataA, wdataB;
  logic        gntA, gntB, stallA;
  logic [31:0] rdataA, rdataB;
  logic        rvalidA, rvalidB, errA, errB;
  logic [31:0] mem_adr, mem_writeData, mem_readData;
  logic        mem_memread, mem_memwrite;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .STARVE_LIMIT(4),
    .LOCK_MAX(8),
    .MEM_WORDS(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reqA(reqA),
    .reqB(reqB),
    .addrA(addrA),
    .addrB(addrB),
    .wdataA(wdataA),
    .wdataB(wdataB),
    .weA(weA),
    .weB(weB),
    .lockB(lockB),
    .gntA(gntA),
    .gntB(gntB),
    .stallA(stallA),
    .rdataA(rdataA),
    .rdataB(rdataB),
    .rvalidA(rvalidA),
    .rvalidB(rvalidB),
    .errA(errA),
    .errB(errB),
    .mem_adr(mem_adr),
    .mem_writeData(mem_writeData),
    .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite),
    .mem_readData(mem_readData)
  );

  // Word memory: asynchronous read, write on the clock edge
  logic [31:0] mem [256] = '{default: 32'h0};
  assign mem_readData = mem[mem_adr[7:0]];
  always @(posedge clk) begin
    if (mem_memwrite)
      mem[mem_adr[7:0]] <= mem_writeData;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    reqA = 1'b0; reqB = 1'b0; weA = 1'b0; weB = 1'b0; lockB = 1'b0;
    addrA = 32'd0; addrB = 32'd0; wdataA = 32'd0; wdataB = 32'd0;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    reqA = req; weA = we; addrA = addr; wdataA = wd;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic lk);
    reqB = req; weB = we; addrB = addr; wdataB = wd; lockB = lk;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;

    // Reset: requests present but nothing granted or driven to memory
    #1;
    drive_a(1'b1, 1'b1, 32'd3, 32'h55);
    drive_b(1'b1, 1'b0, 32'd4, 32'h0, 1'b1);
    #1;
    check_vec("rst_gntA", 32'(gntA), 32'd0);
    check_vec("rst_gntB", 32'(gntB), 32'd0);
    check_vec("rst_stallA", 32'(stallA), 32'd0);
    check_vec("rst_memwrite", 32'(mem_memwrite), 32'd0);
    check_vec("rst_memread", 32'(mem_memread), 32'd0);
    tick();
    tick();
    check_vec("rst_rvalidA", 32'(rvalidA), 32'd0);
    check_vec("rst_errB", 32'(errB), 32'd0);
    check_vec("rst_rdataA", rdataA, 32'd0);
    check_vec("rst_mem_adr", mem_adr, 32'd0);
    idle_inputs();
    rst = 1'b1;
    tick();

    // A writes mem[5]=0x11, then reads it back with latency 1
    drive_a(1'b1, 1'b1, 32'd5, 32'h11);
    #1;
    check_vec("wrA_gntA", 32'(gntA), 32'd1);
    check_vec("wrA_memwrite", 32'(mem_memwrite), 32'd1);
    check_vec("wrA_adr", mem_adr, 32'd5);
    check_vec("wrA_wdata", mem_writeData, 32'h11);
    tick();
    check_vec("wrA_no_rvalid", 32'(rvalidA), 32'd0);
    drive_a(1'b1, 1'b0, 32'd5, 32'h0);
    #1;
    check_vec("rdA_gntA", 32'(gntA), 32'd1);
    check_vec("rdA_memread", 32'(mem_memread), 32'd1);
    tick();
    check_vec("rdA_rvalid", 32'(rvalidA), 32'd1);
    check_vec("rdA_rdata", rdataA, 32'h11);
    idle_inputs();
    #1;
    check_vec("idle_memread", 32'(mem_memread), 32'd0);
    check_vec("idle_adr_hold", mem_adr, 32'd5);
    tick();
    check_vec("idle_rvalid_drop", 32'(rvalidA), 32'd0);
    check_vec("idle_rdata_hold", rdataA, 32'h11);

    // Both ports hold requests: A x4 then forced B, repeating
    drive_a(1'b1, 1'b0, 32'd5, 32'h0);
    drive_b(1'b1, 1'b0, 32'd5, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check_vec($sformatf("starve%0d_gntA", i), 32'(gntA), 32'(i % 5 != 4));
      check_vec($sformatf("starve%0d_gntB", i), 32'(gntB), 32'(i % 5 == 4));
      check_vec($sformatf("starve%0d_stallA", i), 32'(stallA), 32'(i % 5 == 4));
      tick();
      if (i == 4) begin
        check_vec("starve_rvalidB", 32'(rvalidB), 32'd1);
        check_vec("starve_rdataB", rdataB, 32'h11);
      end
    end
    idle_inputs();
    tick();

    // B writes addr 10 = 0xAB taking the lock; A stalls until ARB returns
    drive_b(1'b1, 1'b1, 32'd10, 32'hAB, 1'b1);
    #1;
    check_vec("lkwr_gntB", 32'(gntB), 32'd1);
    check_vec("lkwr_memwrite", 32'(mem_memwrite), 32'd1);
    check_vec("lkwr_adr", mem_adr, 32'd10);
    check_vec("lkwr_wdata", mem_writeData, 32'hAB);
    tick();
    drive_b(1'b0, 1'b0, 32'd0, 32'h0, 1'b1);
    drive_a(1'b1, 1'b0, 32'd10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) lockB = 1'b0;
      #1;
      check_vec($sformatf("lk%0d_gntA", i), 32'(gntA), 32'd0);
      check_vec($sformatf("lk%0d_stallA", i), 32'(stallA), 32'd1);
      tick();
    end
    #1;
    check_vec("unlk_gntA", 32'(gntA), 32'd1);
    check_vec("unlk_adr", mem_adr, 32'd10);
    tick();
    check_vec("unlk_rvalidA", 32'(rvalidA), 32'd1);
    check_vec("unlk_rdataA", rdataA, 32'hAB);
    idle_inputs();
    tick();

    // Lock timeout: 8 LOCK cycles, then A wins and held lockB is ignored
    drive_b(1'b1, 1'b0, 32'd5, 32'h0, 1'b1);
    #1;
    check_vec("tmo_enter_gntB", 32'(gntB), 32'd1);
    tick();
    drive_b(1'b0, 1'b0, 32'd0, 32'h0, 1'b1);
    drive_a(1'b1, 1'b0, 32'd5, 32'h0);
    for (int k = 0; k < 9; k++) begin
      #1;
      check_vec($sformatf("tmo%0d_gntA", k), 32'(gntA), 32'(k == 8));
      tick();
    end
    drive_a(1'b0, 1'b0, 32'd0, 32'h0);
    drive_b(1'b1, 1'b0, 32'd5, 32'h0, 1'b1);
    #1;
    check_vec("inhib_gntB", 32'(gntB), 32'd1);
    tick();
    drive_b(1'b0, 1'b0, 32'd0, 32'h0, 1'b1);
    drive_a(1'b1, 1'b0, 32'd5, 32'h0);
    #1;
    check_vec("inhib_no_lock_gntA", 32'(gntA), 32'd1);
    tick();
    idle_inputs();
    tick();
    drive_b(1'b1, 1'b0, 32'd5, 32'h0, 1'b1);
    #1;
    check_vec("relock_gntB", 32'(gntB), 32'd1);
    tick();
    drive_b(1'b0, 1'b0, 32'd0, 32'h0, 1'b1);
    drive_a(1'b1, 1'b0, 32'd5, 32'h0);
    #1;
    check_vec("relock_gntA", 32'(gntA), 32'd0);
    check_vec("relock_stallA", 32'(stallA), 32'd1);
    tick();

    // Reset for one cycle in LOCK with A pending and a B read offered
    rst = 1'b0;
    drive_b(1'b1, 1'b0, 32'd5, 32'h0, 1'b1);
    #1;
    check_vec("lkrst_gntA", 32'(gntA), 32'd0);
    check_vec("lkrst_gntB", 32'(gntB), 32'd0);
    check_vec("lkrst_stallA", 32'(stallA), 32'd0);
    check_vec("lkrst_memread", 32'(mem_memread), 32'd0);
    tick();
    check_vec("lkrst_rvalidB", 32'(rvalidB), 32'd0);
    check_vec("lkrst_rdataB", rdataB, 32'd0);
    check_vec("lkrst_rdataA", rdataA, 32'd0);
    rst = 1'b1;
    drive_b(1'b0, 1'b0, 32'd0, 32'h0, 1'b0);
    #1;
    check_vec("post_rst_gntA", 32'(gntA), 32'd1);
    check_vec("post_rst_stallA", 32'(stallA), 32'd0);
    tick();
    check_vec("post_rst_rvalidA", 32'(rvalidA), 32'd1);
    check_vec("post_rst_rdataA", rdataA, 32'h11);
    check_vec("post_rst_rvalidB", 32'(rvalidB), 32'd0);
    idle_inputs();

    // Out-of-range accesses: slot consumed, error pulse, zero read data
    drive_b(1'b1, 1'b0, 32'd5, 32'h0, 1'b0);
    tick();
    check_vec("oor_pre_rdataB", rdataB, 32'h11);
    drive_b(1'b1, 1'b0, 32'd300, 32'h0, 1'b0);
    #1;
    check_vec("oorB_gntB", 32'(gntB), 32'd1);
    check_vec("oorB_memread", 32'(mem_memread), 32'd0);
    check_vec("oorB_adr_hold", mem_adr, 32'd5);
    tick();
    check_vec("oorB_errB", 32'(errB), 32'd1);
    check_vec("oorB_rvalidB", 32'(rvalidB), 32'd1);
    check_vec("oorB_rdataB", rdataB, 32'd0);
    idle_inputs();
    drive_a(1'b1, 1'b1, 32'd1000, 32'h77);
    #1;
    check_vec("oorA_memwrite", 32'(mem_memwrite), 32'd0);
    tick();
    check_vec("oorA_errA", 32'(errA), 32'd1);
    check_vec("oorA_no_rvalid", 32'(rvalidA), 32'd0);
    check_vec("oorA_errB_clear", 32'(errB), 32'd0);
    idle_inputs();
    tick();
    check_vec("oorA_err_pulse", 32'(errA), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive cycles port B may be denied before it is force-granted.
REQ-002 The module SHALL have parameter LOCK_MAX, default 8: the maximum number of consecutive cycles in LOCK.
REQ-003 The module SHALL have parameter MEM_WORDS, default 256: the number of valid word addresses in data memory.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have ports reqA / reqB, input, 1 bit each: access request, held until granted.
REQ-007 The module SHALL have ports addrA / addrB, input, 32 bits each: word address.
REQ-008 The module SHALL have ports wdataA / wdataB, input, 32 bits each: write data.
REQ-009 The module SHALL have ports weA / weB, input, 1 bit each: 1 = write, 0 = read.
REQ-010 The module SHALL have port lockB, input, 1 bit: port B requests exclusive ownership of memory.
REQ-011 The module SHALL have ports gntA / gntB, output, 1 bit each: combinational grant, same cycle as the request.
REQ-012 The module SHALL have port stallA, output, 1 bit: equal to reqA & ~gntA, for pipeline freeze.
REQ-013 The module SHALL have ports rdataA / rdataB, output, 32 bits each: registered read data.
REQ-014 The module SHALL have ports rvalidA / rvalidB, output, 1 bit each: one-cycle read-return pulse.
REQ-015 The module SHALL have ports errA / errB, output, 1 bit each: one-cycle out-of-range pulse.
REQ-016 The module SHALL have ports mem_adr and mem_writeData, output, 32 bits each, and mem_memread and mem_memwrite, output, 1 bit each: drive to data memory.
REQ-017 The module SHALL have port mem_readData, input, 32 bits: read data from memory, valid combinationally after mem_adr.

Function
REQ-018 The module SHALL implement a state machine with two states: ARB (normal) and LOCK (B exclusive).
REQ-019 In ARB, the module SHALL assert at most one grant per cycle: gntA if reqA & ~force; otherwise gntB if reqB; force = (starve_cnt == STARVE_LIMIT).
REQ-020 starve_cnt SHALL increment on each cycle with reqB & ~gntB, saturate at STARVE_LIMIT, and clear on gntB or ~reqB.
REQ-021 When force is set and both ports request, the module SHALL grant B, with gntA=0 and stallA=1.
REQ-022 In ARB, gntB with lockB=1 and lock_inhibit=0 SHALL move the state to LOCK on the next cycle and clear lock_cnt.
REQ-023 In LOCK, the module SHALL grant B whenever reqB, SHALL never grant A, and SHALL increment lock_cnt every cycle, including idle cycles.
REQ-024 In LOCK, lockB=0 SHALL return the state to ARB on the next cycle; lockB=0 in the same cycle as a reqB access still grants that access.
REQ-025 In LOCK, reaching lock_cnt == LOCK_MAX-1 SHALL return the state to ARB and set lock_inhibit.
REQ-026 lock_inhibit SHALL clear on the first cycle lockB=0; while it is set, lockB SHALL be ignored.
REQ-027 For a granted in-range access (addr < MEM_WORDS), the module SHALL drive mem_adr = addr, with mem_memwrite = we and mem_memread = ~we.
REQ-028 For a granted write, mem_writeData SHALL equal wdata, and the write SHALL commit on that clock edge.
REQ-029 For a granted read, rdataX SHALL capture mem_readData on that edge, and rvalidX SHALL be 1 for exactly the next cycle (latency 1).
REQ-030 In cycles with no grant, mem_memread and mem_memwrite SHALL be 0, and mem_adr SHALL hold the last granted address (register last_adr) so memory output does not toggle spuriously.
REQ-031 A granted out-of-range access (addr >= MEM_WORDS) SHALL consume the slot with memread=memwrite=0; next cycle errX=1, and for a read also rvalidX=1 with rdataX=0.
REQ-032 Writes SHALL produce no rvalid pulse.
REQ-033 rdataX SHALL hold its value between returns.
REQ-034 Back-to-back grants to the same port SHALL be allowed every cycle.

Reset
REQ-035 While rst=0 at a rising edge, the module SHALL set state=ARB, starve_cnt=0, lock_cnt=0, lock_inhibit=0, last_adr=0, rdataA=rdataB=0, and rvalid*/err*=0.
REQ-036 While rst=0, the module SHALL force gntA=gntB=0, stallA=0, and mem_memread=mem_memwrite=0.
REQ-037 Reset asserted mid-LOCK or during a pending read SHALL abandon the pending read with no rvalid pulse after release.

Verification
REQ-038 The bench SHALL cover: mem[5]=0x11, reqA read addr 5, B idle -> gntA same cycle; next cycle rvalidA=1, rdataA=0x11.
REQ-039 The bench SHALL cover: reqA and reqB held continuously, STARVE_LIMIT=4 -> gntA for 4 cycles, gntB on the 5th, counter cleared, pattern repeats.
REQ-040 The bench SHALL cover: B write addr 10 = 0xAB with lockB=1, then reqA held -> A stalled while lockB=1; A granted the cycle after ARB is re-entered; A read of addr 10 returns 0xAB.
REQ-041 The bench SHALL cover: lockB held 20 cycles, LOCK_MAX=8 -> LOCK exits after 8 cycles, A granted, lockB ignored until it drops low.
REQ-042 The bench SHALL cover: reqB read addr 300 -> mem_memread=0; next cycle errB=1, rvalidB=1, rdataB=0.
REQ-043 The bench SHALL cover: rst=0 for one cycle while in LOCK with reqA pending -> all outputs 0 during reset; after release, state ARB and A granted on the first cycle.
